// File: rtl/fp_cast_share_arbiter_pkg.sv
// Shared widths and the response record for the cast-unit sharing arbiter.
package fp_cast_share_arbiter_pkg;

    localparam int unsigned FP_WIDTH      = 32;
    localparam int unsigned NDSFLAGS_CAST = 3;
    localparam int unsigned NUSFLAGS_CAST = 5;
    localparam int unsigned CAST_NB_REQ   = 4;
    localparam int unsigned CAST_ID_W     = $clog2(CAST_NB_REQ);
    localparam int unsigned CAST_TAG_W    = 5;

    typedef struct packed {
        logic [CAST_ID_W-1:0]     id;
        logic [FP_WIDTH-1:0]      res;
        logic [NUSFLAGS_CAST-1:0] status;
        logic [CAST_TAG_W-1:0]    tag;
    } cast_resp_t;

endpackage

// File: rtl/fp_cast_resp_fifo.sv
// Generic registered FIFO; a push into a full FIFO is accepted when a pop frees the slot.
module fp_cast_resp_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = logic
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  T                           data_i,
    input  logic                       pop_i,
    output T                           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
            end
            if (do_pop) rd_q <= (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/fp_cast_share_arbiter.sv
// Round-robin sharing of one non-stalling cast unit; credits bound in-flight work to the
// response FIFO so requester-side stalls never drop a result.
module fp_cast_share_arbiter
    import fp_cast_share_arbiter_pkg::*;
#(
    parameter int unsigned NB_REQ     = CAST_NB_REQ,
    parameter int unsigned CAST_LAT   = 1,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TAG_WIDTH  = CAST_TAG_W
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NB_REQ-1:0]                 req_i,
    output logic [NB_REQ-1:0]                 gnt_o,
    input  logic [NB_REQ-1:0]                 f2i_i,
    input  logic [NB_REQ*FP_WIDTH-1:0]        opa_i,
    input  logic [NB_REQ*NDSFLAGS_CAST-1:0]   rnd_i,
    input  logic [NB_REQ*TAG_WIDTH-1:0]       tag_i,
    output logic [NB_REQ-1:0]                 resp_valid_o,
    input  logic [NB_REQ-1:0]                 resp_ready_i,
    output logic [FP_WIDTH-1:0]               resp_res_o,
    output logic [NUSFLAGS_CAST-1:0]          resp_status_o,
    output logic [TAG_WIDTH-1:0]              resp_tag_o,
    output logic                              unit_en_o,
    output logic                              unit_f2i_o,
    output logic [FP_WIDTH-1:0]               unit_opa_o,
    output logic [NDSFLAGS_CAST-1:0]          unit_rnd_o,
    output logic [TAG_WIDTH-1:0]              unit_tag_o,
    input  logic                              unit_valid_i,
    input  logic [FP_WIDTH-1:0]               unit_res_i,
    input  logic [NUSFLAGS_CAST-1:0]          unit_status_i,
    input  logic [TAG_WIDTH-1:0]              unit_tag_i
);
    localparam int unsigned ID_W = CAST_ID_W;
    localparam int unsigned CW   = $clog2(FIFO_DEPTH + 1);

    logic [ID_W-1:0] ptr_q, ptr_d, win_id, pipe_id;
    logic            win_vld, grant, pipe_vld, push, pop, fifo_full, fifo_empty;
    logic [CW-1:0]   credits_q, credits_d, fifo_count;
    cast_resp_t      push_data, head;

    // Two passes: requesters at/after the pointer first, then the wrapped-around ones.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        for (int unsigned j = 0; j < NB_REQ; j++) begin
            if (!win_vld && req_i[j] && (32'(ptr_q) <= j)) begin
                win_vld = 1'b1;
                win_id  = ID_W'(j);
            end
        end
        for (int unsigned j = 0; j < NB_REQ; j++) begin
            if (!win_vld && req_i[j]) begin
                win_vld = 1'b1;
                win_id  = ID_W'(j);
            end
        end
    end

    assign grant     = win_vld && (credits_q != '0);
    assign gnt_o     = grant ? (NB_REQ'(1) << win_id) : '0;
    assign unit_en_o = grant;

    always_comb begin
        unit_f2i_o = 1'b0;
        unit_opa_o = '0;
        unit_rnd_o = '0;
        unit_tag_o = '0;
        for (int unsigned k = 0; k < NB_REQ; k++) begin
            if (grant && (win_id == ID_W'(k))) begin
                unit_f2i_o = f2i_i[k];
                unit_opa_o = opa_i[k*FP_WIDTH +: FP_WIDTH];
                unit_rnd_o = rnd_i[k*NDSFLAGS_CAST +: NDSFLAGS_CAST];
                unit_tag_o = tag_i[k*TAG_WIDTH +: TAG_WIDTH];
            end
        end
    end

    assign ptr_d = !grant ? ptr_q
                 : (win_id == ID_W'(NB_REQ - 1)) ? '0 : win_id + 1'b1;

    always_comb begin
        credits_d = credits_q;
        if (grant && !pop)      credits_d = credits_q - 1'b1;
        else if (pop && !grant) credits_d = credits_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q     <= '0;
            credits_q <= CW'(FIFO_DEPTH);
        end else begin
            ptr_q     <= ptr_d;
            credits_q <= credits_d;
        end
    end

    if (CAST_LAT == 0) begin : g_id_comb
        assign pipe_vld = grant;
        assign pipe_id  = win_id;
    end else begin : g_id_pipe
        logic [CAST_LAT-1:0]      vld_q;
        logic [CAST_LAT*ID_W-1:0] id_q;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                vld_q <= '0;
                id_q  <= '0;
            end else begin
                vld_q <= CAST_LAT'({vld_q, grant});
                id_q  <= (CAST_LAT*ID_W)'({id_q, win_id});
            end
        end
        assign pipe_vld = vld_q[CAST_LAT-1];
        assign pipe_id  = id_q[CAST_LAT*ID_W-1 -: ID_W];
    end

    assign push             = unit_valid_i && pipe_vld;
    assign push_data.id     = pipe_id;
    assign push_data.res    = unit_res_i;
    assign push_data.status = unit_status_i;
    assign push_data.tag    = unit_tag_i;

    fp_cast_resp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (cast_resp_t)
    ) i_resp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign resp_valid_o  = fifo_empty ? '0 : (NB_REQ'(1) << head.id);
    assign pop           = |(resp_valid_o & resp_ready_i);
    assign resp_res_o    = fifo_empty ? '0 : head.res;
    assign resp_status_o = fifo_empty ? '0 : head.status;
    assign resp_tag_o    = fifo_empty ? '0 : head.tag;

`ifndef SYNTHESIS
    // A result with no tracked owner is dropped rather than misrouted.
    a_owner_known:  assert property (@(posedge clk_i) disable iff (!rst_ni)
                                     unit_valid_i |-> pipe_vld);
    a_no_overflow:  assert property (@(posedge clk_i) disable iff (!rst_ni)
                                     !(push && fifo_full && !pop));
    a_credit_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                     (32'(credits_q) + 32'(fifo_count)) <= FIFO_DEPTH);
`endif

endmodule
